// File: rtl/pe_array_ctrl.sv
// Sequencer for an N x N output-stationary systolic MAC array: clears the array,
// streams k skewed operand vectors, flushes the pipeline and drains sums row by row.
module pe_array_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  output logic                 busy,
  output logic                 done,
  output logic                 buf_rd_en,
  output logic [KW-1:0]        buf_rd_addr,
  input  logic [8*N-1:0]       buf_data,
  input  logic [8*N-1:0]       buf_weight,
  output logic                 arr_rst_n,
  output logic                 arr_en,
  output logic [8*N-1:0]       arr_data,
  output logic [8*N-1:0]       arr_weight,
  input  logic [32*N*N-1:0]    arr_sum,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [$clog2(N)-1:0] res_row,
  output logic [32*N-1:0]      res_data
);

  localparam int RW = $clog2(N);
  localparam int CW = (KW > $clog2(2*N)) ? KW : $clog2(2*N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_FLUSH,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   k_q, k_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;
  logic            vld_q;
  logic [8*N-1:0]  d_in, w_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      row_q   <= row_d;
      done_q  <= done_d;
      vld_q   <= (state_q == S_FEED);
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // The done cycle is already IDLE, but a start there is deliberately dropped.
        if (start && !done_q) begin
          state_d = S_CLEAR;
          k_d     = k_len;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = (k_q == '0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        if (cnt_q == CW'(k_q) - CW'(1)) begin
          cnt_d   = '0;
          state_d = S_FLUSH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == CW'(2*N-2)) begin
          cnt_d   = '0;
          row_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (res_ready) begin
          if (row_q == RW'(N-1)) begin
            row_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read data lands one cycle after the strobe; outside that window the edge sees zeros.
  assign d_in = vld_q ? buf_data   : '0;
  assign w_in = vld_q ? buf_weight : '0;

  assign arr_data[7:0]   = d_in[7:0];
  assign arr_weight[7:0] = w_in[7:0];

  for (genvar i = 1; i < N; i++) begin : g_skew
    logic [7:0] d_sr_q [i];
    logic [7:0] w_sr_q [i];

    // NOTE: the skew register arrays are reset because their contents reach the
    // array edge directly; a stale operand after an abort would pollute the next run.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < i; s++) begin
          d_sr_q[s] <= '0;
          w_sr_q[s] <= '0;
        end
      end else begin
        d_sr_q[0] <= d_in[8*i +: 8];
        w_sr_q[0] <= w_in[8*i +: 8];
        for (int s = 1; s < i; s++) begin
          d_sr_q[s] <= d_sr_q[s-1];
          w_sr_q[s] <= w_sr_q[s-1];
        end
      end
    end

    assign arr_data[8*i +: 8]   = d_sr_q[i-1];
    assign arr_weight[8*i +: 8] = w_sr_q[i-1];
  end

  always_comb begin
    res_data = '0;
    if (state_q == S_DRAIN) begin
      for (int j = 0; j < N; j++) begin
        res_data[32*j +: 32] = arr_sum[32*(int'(row_q)*N + j) +: 32];
      end
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign buf_rd_en   = (state_q == S_FEED);
  assign buf_rd_addr = (state_q == S_FEED) ? cnt_q[KW-1:0] : '0;
  // Enable starts one cycle after the first read, when operand 0 reaches the edge.
  assign arr_en      = ((state_q == S_FEED) && (cnt_q != '0)) || (state_q == S_FLUSH);
  assign arr_rst_n   = !rst && (state_q != S_CLEAR);
  assign res_valid   = (state_q == S_DRAIN);
  assign res_row     = row_q;

endmodule

// File: tb/tb_pe_array_ctrl.sv
// Bench for pe_array_ctrl: behavioural operand buffer and sign-magnitude PE array,
// directed runs with a scoreboard of expected result rows checked by a monitor.
module tb_pe_array_ctrl;

  localparam int N  = 4;
  localparam int KW = 8;

  typedef struct packed {
    logic [1:0]      row;
    logic [32*N-1:0] data;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 busy, done, buf_rd_en, arr_rst_n, arr_en, res_valid, res_ready;
  logic [KW-1:0]        buf_rd_addr;
  logic [8*N-1:0]       buf_data, buf_weight, arr_data, arr_weight;
  logic [32*N*N-1:0]    arr_sum;
  logic [1:0]           res_row;
  logic [32*N-1:0]      res_data;

  int n_checks = 0;
  int n_pass   = 0;
  beat_t sb[$];
  int rd_log[$];
  int en_cnt, en_runs, done_cnt;
  logic prev_en = 1'b0;

  logic [8*N-1:0] dmem [16];
  logic [8*N-1:0] wmem [16];
  logic [7:0]  pa_q [N][N];
  logic [7:0]  pb_q [N][N];
  logic [31:0] acc  [N][N];

  pe_array_ctrl #(.N(N), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
    .buf_data(buf_data), .buf_weight(buf_weight),
    .arr_rst_n(arr_rst_n), .arr_en(arr_en),
    .arr_data(arr_data), .arr_weight(arr_weight), .arr_sum(arr_sum),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Buffer returns data one cycle after the strobe and junk otherwise.
  always @(posedge clk) begin
    buf_data   <= buf_rd_en ? dmem[buf_rd_addr] : {N{8'h5A}};
    buf_weight <= buf_rd_en ? wmem[buf_rd_addr] : {N{8'hA5}};
  end

  function automatic logic [31:0] smul(input logic [7:0] a, input logic [7:0] b);
    logic [13:0] m;
    logic [31:0] p;
    m = 14'(a[6:0]) * 14'(b[6:0]);
    p = {18'd0, m};
    return (a[7] ^ b[7]) ? -p : p;
  endfunction

  // Output-stationary array: data moves right, weights move down, sums stay put.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!arr_rst_n) begin
          pa_q[i][j] <= '0;
          pb_q[i][j] <= '0;
          acc[i][j]  <= '0;
        end else if (arr_en) begin
          pa_q[i][j] <= (j == 0) ? arr_data[8*i +: 8]   : pa_q[i][j-1];
          pb_q[i][j] <= (i == 0) ? arr_weight[8*j +: 8] : pb_q[i-1][j];
          acc[i][j]  <= acc[i][j] + smul((j == 0) ? arr_data[8*i +: 8]   : pa_q[i][j-1],
                                         (i == 0) ? arr_weight[8*j +: 8] : pb_q[i-1][j]);
        end
      end
    end
  end

  always_comb begin
    arr_sum = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        arr_sum[32*(i*N+j) +: 32] = acc[i][j];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [127:0] row4(input logic [31:0] s0, input logic [31:0] s1,
                                        input logic [31:0] s2, input logic [31:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  task automatic push_row(input int r, input logic [127:0] d);
    beat_t b;
    b.row  = 2'(r);
    b.data = d;
    sb.push_back(b);
  endtask

  task automatic set_vec(input int a, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3,
                         input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
    dmem[a] = {d3, d2, d1, d0};
    wmem[a] = {w3, w2, w1, w0};
  endtask

  // Scoreboard monitor: pops on every accepted beat, checks stability while stalled.
  initial begin
    beat_t exp_b;
    logic prev_stall;
    logic [1:0] prev_row;
    logic [127:0] prev_data;
    prev_stall = 1'b0;
    prev_row   = '0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && res_valid) begin
          check("stall_row_stable",  128'(res_row), 128'(prev_row));
          check("stall_data_stable", res_data, prev_data);
        end
        if (res_valid && res_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_beat: row %0d presented with nothing expected", res_row);
          end else begin
            exp_b = sb.pop_front();
            check("beat_row", 128'(res_row), 128'(exp_b.row));
            check($sformatf("row%0d_data", exp_b.row), res_data, exp_b.data);
          end
        end
        prev_stall = res_valid && !res_ready;
        prev_row   = res_row;
        prev_data  = res_data;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (arr_en) en_cnt++;
      if (arr_en && !prev_en) en_runs++;
      prev_en = arr_en;
      if (buf_rd_en) rd_log.push_back(int'(buf_rd_addr));
      if (done) done_cnt++;
    end
  end

  // Latency counts the CLEAR, FEED and FLUSH cycles that precede the first result beat.
  task automatic run(input int k, input bit stall, input bit probe);
    int lat, w, exp_lat;
    en_cnt = 0; en_runs = 0; done_cnt = 0;
    rd_log.delete();
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    start = 1'b0;
    k_len = 8'hFF;
    lat = 0;
    while (!res_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    exp_lat = (k == 0) ? 1 : 1 + k + (2*N - 1);
    check("latency", 128'(lat), 128'(exp_lat));
    if (stall) begin
      @(posedge clk); #1;
      res_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 res_ready = 1'b1;
    end
    w = 0;
    while (!done && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("done_seen", 128'(done), 128'(1));
    check("busy_low_at_done", 128'(busy), 128'(0));
    check("sb_drained", 128'(sb.size()), 128'(0));
    if (probe) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_one_cycle", 128'(done), 128'(0));
    check("done_pulse_count", 128'(done_cnt), 128'(1));
    if (probe) check("start_in_done_ignored", 128'(busy), 128'(0));
    check("arr_en_cycles", 128'(en_cnt), 128'((k == 0) ? 0 : k + 2*N - 2));
    check("arr_en_runs", 128'(en_runs), 128'((k == 0) ? 0 : 1));
    check("rd_count", 128'(rd_log.size()), 128'(k));
    for (int i = 0; i < rd_log.size() && i < k; i++)
      check("rd_addr", 128'(rd_log[i]), 128'(i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; k_len = '0; res_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      dmem[a] = '0;
      wmem[a] = '0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_busy",      128'(busy),        128'(0));
    check("rst_done",      128'(done),        128'(0));
    check("rst_rd_en",     128'(buf_rd_en),   128'(0));
    check("rst_arr_en",    128'(arr_en),      128'(0));
    check("rst_res_valid", 128'(res_valid),   128'(0));
    check("rst_rd_addr",   128'(buf_rd_addr), 128'(0));
    check("rst_arr_data",  128'(arr_data),    128'(0));
    check("rst_arr_wgt",   128'(arr_weight),  128'(0));
    check("rst_res_row",   128'(res_row),     128'(0));
    check("rst_res_data",  res_data,          128'(0));
    check("rst_arr_rst_n", 128'(arr_rst_n),   128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_arr_rst_n", 128'(arr_rst_n), 128'(1));

    // k=1, data {3,2}, weights {4,5}: outer product in the top-left 2x2.
    set_vec(0, 3, 2, 0, 0, 4, 5, 0, 0);
    push_row(0, row4(12, 15, 0, 0));
    push_row(1, row4(8, 10, 0, 0));
    push_row(2, '0);
    push_row(3, '0);
    run(1, 1'b0, 1'b0);

    // Sign-magnitude: 0x83 is -3, so -3*4 and -3*5.
    set_vec(0, 8'h83, 0, 0, 0, 4, 5, 0, 0);
    push_row(0, row4(32'hFFFF_FFF4, 32'hFFFF_FFF1, 0, 0));
    push_row(1, '0);
    push_row(2, '0);
    push_row(3, '0);
    run(1, 1'b0, 1'b0);

    // k=3, all data 1, all weights 2: every sum is 3*2.
    for (int a = 0; a < 3; a++) set_vec(a, 1, 1, 1, 1, 2, 2, 2, 2);
    for (int r = 0; r < 4; r++) push_row(r, row4(6, 6, 6, 6));
    run(3, 1'b0, 1'b0);

    // k=0: the CLEAR wipes the previous sums, no reads, start in done cycle dropped.
    for (int r = 0; r < 4; r++) push_row(r, '0);
    run(0, 1'b0, 1'b1);

    // k=2 with distinct rows, sum(i,j)=i+1+j; row 1 is stalled for 5 cycles.
    set_vec(0, 1, 2, 3, 4, 1, 1, 1, 1);
    set_vec(1, 1, 1, 1, 1, 0, 1, 2, 3);
    for (int r = 0; r < 4; r++) push_row(r, row4(r+1, r+2, r+3, r+4));
    run(2, 1'b1, 1'b0);

    // Abort mid-FEED, then a fresh k=1 run must show no leftover accumulation.
    for (int a = 0; a < 10; a++) set_vec(a, 7, 7, 7, 7, 7, 7, 7, 7);
    start = 1'b1;
    k_len = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_in_feed", 128'(buf_rd_en), 128'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy",     128'(busy),       128'(0));
    check("abort_rd_en",    128'(buf_rd_en),  128'(0));
    check("abort_arr_en",   128'(arr_en),     128'(0));
    check("abort_arr_data", 128'(arr_data),   128'(0));
    check("abort_arr_wgt",  128'(arr_weight), 128'(0));
    check("abort_rst_n",    128'(arr_rst_n),  128'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_rst_n", 128'(arr_rst_n), 128'(1));
    set_vec(0, 3, 2, 0, 0, 4, 5, 0, 0);
    push_row(0, row4(12, 15, 0, 0));
    push_row(1, row4(8, 10, 0, 0));
    push_row(2, '0);
    push_row(3, '0);
    run(1, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
